// File: rtl/passive_alarm_ctrl_if.sv
// Sensor inputs and warning/actuator outputs of the passive-security alarm controller.
interface passive_alarm_ctrl_if;
    logic       CarLightsOnSign;
    logic       OpenDoorSign;
    logic       IgnitionSignalOn;
    logic       AckButton;
    logic       BuzzerOut;
    logic       WarningLed;
    logic       LightsCutOff;
    logic [2:0] State;

    modport master (
        output CarLightsOnSign, OpenDoorSign, IgnitionSignalOn, AckButton,
        input  BuzzerOut, WarningLed, LightsCutOff, State
    );

    modport slave (
        input  CarLightsOnSign, OpenDoorSign, IgnitionSignalOn, AckButton,
        output BuzzerOut, WarningLed, LightsCutOff, State
    );
endinterface

// File: rtl/passive_alarm_ctrl.sv
// Passive car-security warning: debounces lights/door/ignition/ack and sequences
// grace delay, pulsed chime, driver silence and automatic light cut-off.
module passive_alarm_ctrl #(
    parameter int DEB_CYCLES   = 4,
    parameter int GRACE_CYCLES = 8,
    parameter int CHIME_HALF   = 4,
    parameter int CHIME_COUNT  = 3,
    parameter int CNT_W        = 8
) (
    input  logic                 Clk,
    input  logic                 Reset,
    passive_alarm_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ARMED    = 3'd1,
        CHIME    = 3'd2,
        SILENCED = 3'd3,
        CUTOFF   = 3'd4
    } stateT;

    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] GRACE_LAST  = CNT_W'(GRACE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HALF        = CNT_W'(CHIME_HALF);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(2 * CHIME_HALF - 1);
    localparam logic [CNT_W-1:0] BURST_LAST  = CNT_W'(CHIME_COUNT - 1);

    logic [3:0]       rawVec;
    logic [3:0]       debVal;
    logic [CNT_W-1:0] debCnt [4];
    logic             lightsD, doorD, ignD, ackD, cond;

    stateT            state;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] burst;

    assign rawVec = {bus.AckButton, bus.IgnitionSignalOn, bus.OpenDoorSign, bus.CarLightsOnSign};

    // Same debouncer for every input: flip only after DEB_CYCLES consecutive disagreements.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            debVal <= '0;
            for (int i = 0; i < 4; i++) debCnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (rawVec[i] == debVal[i]) begin
                    debCnt[i] <= '0;
                end else if (debCnt[i] == DEB_LAST) begin
                    debVal[i] <= rawVec[i];
                    debCnt[i] <= '0;
                end else begin
                    debCnt[i] <= debCnt[i] + 1'b1;
                end
            end
        end
    end

    assign lightsD = debVal[0];
    assign doorD   = debVal[1];
    assign ignD    = debVal[2];
    assign ackD    = debVal[3];
    assign cond    = lightsD & doorD & ~ignD;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            timer <= '0;
            burst <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cond) begin
                        state <= ARMED;
                        timer <= '0;
                    end
                end
                ARMED: begin
                    if (!cond) begin
                        state <= IDLE;
                    end else if (timer == GRACE_LAST) begin
                        state <= CHIME;
                        timer <= '0;
                        burst <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                CHIME: begin
                    // Abort beats acknowledge, which beats the final-period expiry.
                    if (!cond) begin
                        state <= IDLE;
                    end else if (ackD) begin
                        state <= SILENCED;
                    end else if (timer == PERIOD_LAST) begin
                        if (burst == BURST_LAST) begin
                            state <= CUTOFF;
                        end else begin
                            timer <= '0;
                            burst <= burst + 1'b1;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                SILENCED: begin
                    if (!cond) state <= IDLE;
                end
                CUTOFF: begin
                    // Lights drop as a result of the cut-off, so only ignition may release it.
                    if (ignD) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.BuzzerOut    = (state == CHIME) && (timer < HALF);
    assign bus.WarningLed   = (state == ARMED) || (state == CHIME) || (state == SILENCED);
    assign bus.LightsCutOff = (state == CUTOFF);
    assign bus.State        = state;

endmodule

// File: tb/tb_passive_alarm_ctrl.sv
// Scoreboard bench for passive_alarm_ctrl: each driven cycle pushes its expected
// {State, BuzzerOut, WarningLed, LightsCutOff}, which is popped and compared after the edge.
module tb_passive_alarm_ctrl;

    logic Clk;
    logic Reset;
    int   checks;
    int   failures;
    logic [5:0] sbq [$];

    passive_alarm_ctrl_if bus ();

    passive_alarm_ctrl #(
        .DEB_CYCLES  (4),
        .GRACE_CYCLES(8),
        .CHIME_HALF  (4),
        .CHIME_COUNT (3),
        .CNT_W       (8)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [5:0] mk(input int st, input bit buz);
        logic [2:0] s;
        s = 3'(st);
        return {s, buz, (st == 1 || st == 2 || st == 3), (st == 4)};
    endfunction

    // Undisturbed timeline with lights=1, door=1, ign=0 raised before edge 1.
    function automatic logic [5:0] seqExp(input int e);
        if (e < 5)  return mk(0, 1'b0);
        if (e < 13) return mk(1, 1'b0);
        if (e < 37) return mk(2, ((e - 13) % 8) < 4);
        return mk(4, 1'b0);
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [5:0] observed();
        return {bus.State, bus.BuzzerOut, bus.WarningLed, bus.LightsCutOff};
    endfunction

    task automatic setInputs(input bit l, input bit d, input bit i, input bit a);
        bus.CarLightsOnSign  = l;
        bus.OpenDoorSign     = d;
        bus.IgnitionSignalOn = i;
        bus.AckButton        = a;
    endtask

    task automatic doReset();
        setInputs(0, 0, 0, 0);
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [5:0] got, exp;
        setInputs(0, 0, 0, 0);
        Reset = 1'b1;
        for (int e = 1; e <= 2; e++) begin
            sbq.push_back(mk(0, 1'b0));
            tick();
            got = observed();
            exp = sbq.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL reset edge %0d: got %b want %b", e, got, exp);
            end
        end
        Reset = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            bus.OpenDoorSign = (e <= 3);
            sbq.push_back(mk(0, 1'b0));
            tick();
            got = observed();
            exp = sbq.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL door_glitch edge %0d: got %b want %b", e, got, exp);
            end
        end
    endtask

    task automatic test_full_sequence();
        logic [5:0] got, exp;
        doReset();
        setInputs(1, 1, 0, 0);
        for (int e = 1; e <= 50; e++) begin
            if (e == 38) bus.CarLightsOnSign = 1'b0;
            if (e == 45) bus.IgnitionSignalOn = 1'b1;
            if (e <= 37)      sbq.push_back(seqExp(e));
            else if (e <= 48) sbq.push_back(mk(4, 1'b0));
            else              sbq.push_back(mk(0, 1'b0));
            tick();
            got = observed();
            exp = sbq.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL full_seq edge %0d: got %b want %b", e, got, exp);
            end
        end
    endtask

    task automatic test_silence();
        logic [5:0] got, exp;
        doReset();
        setInputs(1, 1, 0, 0);
        for (int e = 1; e <= 40; e++) begin
            bus.AckButton    = (e >= 23 && e <= 26);
            bus.OpenDoorSign = (e < 35);
            if (e <= 26)      sbq.push_back(seqExp(e));
            else if (e <= 38) sbq.push_back(mk(3, 1'b0));
            else              sbq.push_back(mk(0, 1'b0));
            tick();
            got = observed();
            exp = sbq.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL silence edge %0d: got %b want %b", e, got, exp);
            end
        end
    endtask

    task automatic test_abort_armed();
        logic [5:0] got, exp;
        doReset();
        setInputs(1, 1, 0, 0);
        for (int e = 1; e <= 18; e++) begin
            bus.OpenDoorSign = !((e >= 6 && e <= 7) || (e >= 9 && e <= 12));
            if (e < 5)       sbq.push_back(mk(0, 1'b0));
            else if (e < 13) sbq.push_back(mk(1, 1'b0));
            else if (e < 17) sbq.push_back(mk(0, 1'b0));
            else             sbq.push_back(mk(1, 1'b0));
            tick();
            got = observed();
            exp = sbq.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL abort_armed edge %0d: got %b want %b", e, got, exp);
            end
        end
    endtask

    task automatic test_reset_in_chime();
        logic [5:0] got, exp;
        doReset();
        setInputs(1, 1, 0, 0);
        for (int e = 1; e <= 22; e++) begin
            Reset = (e == 15);
            if (e <= 14)      sbq.push_back(seqExp(e));
            else if (e <= 19) sbq.push_back(mk(0, 1'b0));
            else              sbq.push_back(mk(1, 1'b0));
            tick();
            got = observed();
            exp = sbq.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL reset_in_chime edge %0d: got %b want %b", e, got, exp);
            end
        end
        Reset = 1'b0;
    endtask

    task automatic test_simultaneous();
        logic [5:0] got, exp;
        doReset();
        setInputs(1, 1, 0, 0);
        for (int e = 1; e <= 20; e++) begin
            bus.OpenDoorSign = (e < 15);
            bus.AckButton    = (e >= 15);
            if (e <= 18) sbq.push_back(seqExp(e));
            else         sbq.push_back(mk(0, 1'b0));
            tick();
            got = observed();
            exp = sbq.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL ack_vs_cond edge %0d: got %b want %b", e, got, exp);
            end
        end
    endtask

    task automatic test_ack_at_expiry();
        logic [5:0] got, exp;
        doReset();
        setInputs(1, 1, 0, 0);
        for (int e = 1; e <= 40; e++) begin
            bus.AckButton = (e >= 33);
            if (e <= 36) sbq.push_back(seqExp(e));
            else         sbq.push_back(mk(3, 1'b0));
            tick();
            got = observed();
            exp = sbq.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL ack_at_expiry edge %0d: got %b want %b", e, got, exp);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        Reset    = 1'b1;
        setInputs(0, 0, 0, 0);
        test_reset();
        test_full_sequence();
        test_silence();
        test_abort_armed();
        test_reset_in_chime();
        test_simultaneous();
        test_ack_at_expiry();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
